// File: rtl/mem_bus_responder_if.sv
// Bus between the CPU controller and the memory responder.
// The master drives strobes, address and write data; the slave returns completion status.
interface mem_bus_responder_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 13
);
  logic              rd;
  logic              wr;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_in;
  logic [1:0]        wait_cfg;
  logic [DATA_W-1:0] data_out;
  logic              data_oe;
  logic              ready;
  logic              err;
  logic              busy;

  modport master (
    output rd, wr, addr, data_in, wait_cfg,
    input  data_out, data_oe, ready, err, busy
  );

  modport slave (
    input  rd, wr, addr, data_in, wait_cfg,
    output data_out, data_oe, ready, err, busy
  );
endinterface

// File: rtl/mem_bus_responder.sv
// Memory-bus responder: one 256-entry RAM page with programmable wait states.
// Accesses outside the page complete with err; a dropped strobe aborts the access.
module mem_bus_responder #(
  parameter int                DATA_W   = 8,
  parameter int                ADDR_W   = 13,
  parameter logic [ADDR_W-9:0] RAM_PAGE = 5'h18
) (
  input  logic                 clk,
  input  logic                 reset,
  mem_bus_responder_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            r_state;
  logic [1:0]        r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_dout;
  logic              r_isWrite;
  logic              r_oe;
  logic              r_ready;
  logic              r_err;
  logic              r_busy;
  logic [DATA_W-1:0] r_mem [0:255];

  logic w_inPage;
  logic w_held;
  logic w_memWe;

  assign w_inPage = (r_addr[ADDR_W-1:8] == RAM_PAGE);
  assign w_held   = r_isWrite ? bus.wr : bus.rd;
  // The RAM is written only on the completing edge; an abort or reset suppresses it.
  assign w_memWe  = (r_state == BUSY) && (r_cnt == 2'd0) && w_held &&
                    r_isWrite && w_inPage && !reset;

  // RAM contents survive reset, so the array lives outside the reset domain.
  always_ff @(posedge clk) begin
    if (w_memWe) r_mem[r_addr[7:0]] <= r_wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= 2'd0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_dout    <= '0;
      r_isWrite <= 1'b0;
      r_oe      <= 1'b0;
      r_ready   <= 1'b0;
      r_err     <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.rd ^ bus.wr) begin
            r_addr    <= bus.addr;
            r_wdata   <= bus.data_in;
            r_isWrite <= bus.wr;
            r_cnt     <= bus.wait_cfg;
            r_busy    <= 1'b1;
            r_state   <= BUSY;
          end else if (bus.rd && bus.wr) begin
            r_err <= 1'b1;
          end
        end
        BUSY: begin
          if (!w_held) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else if (r_cnt != 2'd0) begin
            r_cnt <= r_cnt - 2'd1;
          end else begin
            r_ready <= 1'b1;
            r_err   <= !w_inPage;
            r_state <= DONE;
            if (!r_isWrite) begin
              r_dout <= w_inPage ? r_mem[r_addr[7:0]] : '0;
              r_oe   <= w_inPage;
            end
          end
        end
        DONE: begin
          // Waiting for both strobes low keeps a held strobe from starting a second access.
          if (!bus.rd && !bus.wr) begin
            r_oe    <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.data_out = r_dout;
  assign bus.data_oe  = r_oe;
  assign bus.ready    = r_ready;
  assign bus.err      = r_err;
  assign bus.busy     = r_busy;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Self-checking bench for mem_bus_responder: a table of accesses checked through a
// scoreboard queue, plus hand-written sequences for collision, abort and reset.
module tb_mem_bus_responder;

  logic clk;
  logic reset;

  mem_bus_responder_if #(.DATA_W(8), .ADDR_W(13)) busIf ();

  mem_bus_responder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (busIf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    bit          isWr;
    logic [12:0] addr;
    logic [7:0]  data;
    logic [1:0]  waitCfg;
    logic [7:0]  expData;
    bit          expErr;
  } vec_t;

  typedef struct {
    bit         isRead;
    logic [7:0] expData;
    bit         expErr;
    int         expLat;
  } exp_t;

  vec_t vecs[10];
  exp_t sbQ[$];
  int   nChecks = 0;
  int   nFails  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one access and record what the responder owes us for it.
  task automatic applyStimulus(input vec_t v);
    exp_t e;
    e.isRead  = !v.isWr;
    e.expData = v.expData;
    e.expErr  = v.expErr;
    e.expLat  = int'(v.waitCfg) + 1;
    sbQ.push_back(e);
    @(negedge clk);
    busIf.rd       = !v.isWr;
    busIf.wr       = v.isWr;
    busIf.addr     = v.addr;
    busIf.data_in  = v.data;
    busIf.wait_cfg = v.waitCfg;
  endtask

  // Watch for the completion, compare it with the scoreboard, then release the strobe.
  task automatic checkOutput(input vec_t v);
    exp_t e;
    int   lat = 0;
    bit   got = 1'b0;
    logic [7:0] dOut = '0;
    bit   dOe = 1'b0;
    bit   eFlag = 1'b0;
    @(posedge clk); #1;
    check("busyAfterAccept", busIf.busy, 1);
    busIf.wait_cfg = ~v.waitCfg;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk); #1;
      lat++;
      if (busIf.ready) begin
        got   = 1'b1;
        dOut  = busIf.data_out;
        dOe   = busIf.data_oe;
        eFlag = busIf.err;
      end
    end
    e = sbQ.pop_front();
    check("readySeen", got, 1);
    if (got) begin
      check("latency", lat, e.expLat);
      check("errFlag", eFlag, e.expErr);
      if (e.isRead) check("readData", dOut, e.expData);
      if (e.isRead && !e.expErr) check("dataOe", dOe, 1);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("readyOnce", busIf.ready, 0);
      check("busyInDone", busIf.busy, 1);
      if (e.isRead && !e.expErr) check("dataHeld", busIf.data_out, e.expData);
    end
    @(negedge clk);
    busIf.rd = 1'b0;
    busIf.wr = 1'b0;
    @(posedge clk); #1;
    check("busyIdle", busIf.busy, 0);
    check("oeCleared", busIf.data_oe, 0);
  endtask

  task automatic runAccess(input vec_t v);
    applyStimulus(v);
    checkOutput(v);
  endtask

  function automatic vec_t mkVec(input bit w, input logic [12:0] a, input logic [7:0] d,
                                 input logic [1:0] wc, input logic [7:0] ed, input bit ee);
    vec_t v;
    v.isWr = w; v.addr = a; v.data = d; v.waitCfg = wc; v.expData = ed; v.expErr = ee;
    return v;
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int readyCnt;

    vecs[0] = mkVec(1'b1, 13'h1805, 8'hA5, 2'd0, 8'h00, 1'b0);
    vecs[1] = mkVec(1'b0, 13'h1805, 8'h00, 2'd0, 8'hA5, 1'b0);
    vecs[2] = mkVec(1'b1, 13'h18FF, 8'h3C, 2'd1, 8'h00, 1'b0);
    vecs[3] = mkVec(1'b0, 13'h18FF, 8'h00, 2'd3, 8'h3C, 1'b0);
    vecs[4] = mkVec(1'b1, 13'h1800, 8'h77, 2'd2, 8'h00, 1'b0);
    vecs[5] = mkVec(1'b1, 13'h0100, 8'h5A, 2'd0, 8'h00, 1'b1);
    vecs[6] = mkVec(1'b0, 13'h1800, 8'h00, 2'd0, 8'h77, 1'b0);
    vecs[7] = mkVec(1'b0, 13'h0100, 8'h00, 2'd0, 8'h00, 1'b1);
    vecs[8] = mkVec(1'b1, 13'h1810, 8'h11, 2'd0, 8'h00, 1'b0);
    vecs[9] = mkVec(1'b0, 13'h1810, 8'h00, 2'd3, 8'h11, 1'b0);

    reset          = 1'b1;
    busIf.rd       = 1'b0;
    busIf.wr       = 1'b0;
    busIf.addr     = '0;
    busIf.data_in  = '0;
    busIf.wait_cfg = '0;
    #1;
    check("rstDataOut", busIf.data_out, 0);
    check("rstDataOe", busIf.data_oe, 0);
    check("rstReady", busIf.ready, 0);
    check("rstErr", busIf.err, 0);
    check("rstBusy", busIf.busy, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) runAccess(vecs[i]);

    // Both strobes at once: rejected with a lone err pulse.
    @(negedge clk);
    busIf.rd = 1'b1; busIf.wr = 1'b1; busIf.addr = 13'h1805; busIf.data_in = 8'hFF;
    busIf.wait_cfg = 2'd0;
    @(posedge clk); #1;
    check("collideErr", busIf.err, 1);
    check("collideReady", busIf.ready, 0);
    check("collideBusy", busIf.busy, 0);
    @(negedge clk);
    busIf.rd = 1'b0; busIf.wr = 1'b0;
    @(posedge clk); #1;
    check("collideErrPulse", busIf.err, 0);
    runAccess(mkVec(1'b0, 13'h1805, 8'h00, 2'd0, 8'hA5, 1'b0));

    // Write strobe dropped mid-access: abort, no ready, RAM untouched.
    @(negedge clk);
    busIf.wr = 1'b1; busIf.addr = 13'h1810; busIf.data_in = 8'h33; busIf.wait_cfg = 2'd2;
    @(posedge clk); #1;
    check("abortAccepted", busIf.busy, 1);
    @(negedge clk);
    busIf.wr = 1'b0;
    @(posedge clk); #1;
    check("abortBusy", busIf.busy, 0);
    check("abortOe", busIf.data_oe, 0);
    readyCnt = 0;
    if (busIf.ready) readyCnt++;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (busIf.ready) readyCnt++;
    end
    check("abortNoReady", readyCnt, 0);
    runAccess(mkVec(1'b0, 13'h1810, 8'h00, 2'd0, 8'h11, 1'b0));

    // Reset during a write's wait states clears outputs without a clock edge.
    @(negedge clk);
    busIf.wr = 1'b1; busIf.addr = 13'h1805; busIf.data_in = 8'hEE; busIf.wait_cfg = 2'd3;
    @(posedge clk); #1;
    check("rstMidBusy", busIf.busy, 1);
    @(negedge clk); #2;
    reset = 1'b1;
    #1;
    check("rstMidDataOut", busIf.data_out, 0);
    check("rstMidOe", busIf.data_oe, 0);
    check("rstMidReady", busIf.ready, 0);
    check("rstMidErr", busIf.err, 0);
    check("rstMidBusyLow", busIf.busy, 0);
    busIf.wr = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    runAccess(mkVec(1'b0, 13'h1805, 8'h00, 2'd1, 8'hA5, 1'b0));

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
